vproc_result_order: RTL

VPROC_RESULT_ORDER -- requirements
Module: vproc_result_order

---
 rtl/vproc_result_order_if.sv | 35 +++
 rtl/vproc_result_order.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/vproc_result_order_if.sv
// rtl/vproc_result_order_if.sv - in-order result channel interface
//
// Purpose: carries one retired result from vproc_result_order to its consumer.
// Signals:
//   valid   - result register holds a result
//   ready   - consumer accepts the result this cycle
//   id      - instruction ID of the result
//   data    - 32-bit result value
//   rd      - destination register index
//   we      - register write enable
//   exc     - exception flag
//   exccode - exception code
// Modports: master (result producer), slave (result consumer).
interface vproc_result_order_if #(
  parameter int XIF_ID_W = 3
);
  logic                valid;
  logic                ready;
  logic [XIF_ID_W-1:0] id;
  logic [31:0]         data;
  logic [4:0]          rd;
  logic                we;
  logic                exc;
  logic [5:0]          exccode;

  modport master (
    output valid, id, data, rd, we, exc, exccode,
    input  ready
  );

  modport slave (
    input  valid, id, data, rd, we, exc, exccode,
    output ready
  );
endinterface

// File: rtl/vproc_result_order.sv
// rtl/vproc_result_order.sv - retires results from several sources in issue order
//
// Purpose: records issued instruction IDs in a circular order FIFO and only
// accepts a result from a source whose ID matches the oldest outstanding ID.
// The accepted result is held in a single output register.
// Ports:
//   clk_i, sync_rst_i           - clock, synchronous active-high reset
//   issue_valid_i/ready_o/id_i  - push of an issued instruction ID
//   src_valid_i/ready_o/id_i    - per-source result requests (index 0 wins)
//   src_data_i/rd_i/we_i/exc_i/exccode_i - per-source result payload
//   res_if                      - in-order result channel (master side)
//   pending_cnt_o               - number of IDs waiting in the order FIFO
module vproc_result_order #(
  parameter int XIF_ID_W       = 3,
  parameter int SRC_CNT        = 4,
  parameter bit DONT_CARE_ZERO = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         sync_rst_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [XIF_ID_W-1:0]          issue_id_i,
  input  logic [SRC_CNT-1:0]           src_valid_i,
  output logic [SRC_CNT-1:0]           src_ready_o,
  input  logic [SRC_CNT*XIF_ID_W-1:0]  src_id_i,
  input  logic [SRC_CNT*32-1:0]        src_data_i,
  input  logic [SRC_CNT*5-1:0]         src_rd_i,
  input  logic [SRC_CNT-1:0]           src_we_i,
  input  logic [SRC_CNT-1:0]           src_exc_i,
  input  logic [SRC_CNT*6-1:0]         src_exccode_i,
  vproc_result_order_if.master         res_if,
  output logic [XIF_ID_W:0]            pending_cnt_o
);

  localparam int N = 1 << XIF_ID_W;
  localparam logic [XIF_ID_W:0] FULL_CNT = (XIF_ID_W+1)'(N);

  logic [XIF_ID_W-1:0] fifo_q [N];
  logic [XIF_ID_W-1:0] head_q, head_d;
  logic [XIF_ID_W-1:0] tail_q, tail_d;
  logic [XIF_ID_W:0]   count_q, count_d;

  logic                res_valid_q, res_valid_d;
  logic [XIF_ID_W-1:0] res_id_q;
  logic [31:0]         res_data_q;
  logic [4:0]          res_rd_q;
  logic                res_we_q;
  logic                res_exc_q;
  logic [5:0]          res_exccode_q;

  logic                head_valid;
  logic [XIF_ID_W-1:0] head_id;
  logic                push;
  logic                pop;
  logic                out_free;
  logic                found;
  logic [SRC_CNT-1:0]  grant;
  logic [XIF_ID_W-1:0] sel_id;
  logic [31:0]         sel_data;
  logic [4:0]          sel_rd;
  logic                sel_we;
  logic                sel_exc;
  logic [5:0]          sel_exccode;

  // Full is judged on the registered count only, so a pop in the same cycle
  // never frees a slot for a push; this keeps ready off the grant path.
  assign issue_ready_o = (count_q != FULL_CNT);
  assign push          = issue_valid_i & issue_ready_o;
  assign head_valid    = (count_q != '0);
  assign head_id       = fifo_q[head_q];
  assign out_free      = ~res_valid_q | res_if.ready;

  // Priority search: first source (lowest index) carrying the head ID.
  always_comb begin
    found       = 1'b0;
    grant       = '0;
    sel_id      = '0;
    sel_data    = '0;
    sel_rd      = '0;
    sel_we      = 1'b0;
    sel_exc     = 1'b0;
    sel_exccode = '0;
    for (int i = 0; i < SRC_CNT; i++) begin
      if (!found && src_valid_i[i] && head_valid &&
          (src_id_i[i*XIF_ID_W +: XIF_ID_W] == head_id)) begin
        found       = 1'b1;
        grant[i]    = 1'b1;
        sel_id      = src_id_i[i*XIF_ID_W +: XIF_ID_W];
        sel_data    = src_data_i[i*32 +: 32];
        sel_rd      = src_rd_i[i*5 +: 5];
        sel_we      = src_we_i[i];
        sel_exc     = src_exc_i[i];
        sel_exccode = src_exccode_i[i*6 +: 6];
      end
    end
  end

  assign pop         = found & out_free;
  assign src_ready_o = out_free ? grant : '0;

  always_comb begin
    head_d      = pop  ? head_q + 1'b1 : head_q;
    tail_d      = push ? tail_q + 1'b1 : tail_q;
    count_d     = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
    res_valid_d = res_valid_q;
    if (pop)               res_valid_d = 1'b1;
    else if (res_if.ready) res_valid_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Storage without reset: contents are only observed behind count/valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[tail_q] <= issue_id_i;
    if (pop) begin
      res_id_q      <= sel_id;
      res_data_q    <= sel_data;
      res_rd_q      <= sel_rd;
      res_we_q      <= sel_we;
      res_exc_q     <= sel_exc;
      res_exccode_q <= sel_exccode;
    end
  end

  assign res_if.valid   = res_valid_q;
  assign res_if.we      = res_valid_q & res_we_q;
  assign res_if.exc     = res_valid_q & res_exc_q;
  assign res_if.id      = res_valid_q ? res_id_q      : (DONT_CARE_ZERO ? '0 : 'x);
  assign res_if.data    = res_valid_q ? res_data_q    : (DONT_CARE_ZERO ? '0 : 'x);
  assign res_if.rd      = res_valid_q ? res_rd_q      : (DONT_CARE_ZERO ? '0 : 'x);
  assign res_if.exccode = res_valid_q ? res_exccode_q : (DONT_CARE_ZERO ? '0 : 'x);
  assign pending_cnt_o  = count_q;

endmodule
